// File: rtl/bin_bcd_7seg_seq_anode_if.sv
// Handshake and result bundle for bin_bcd_7seg_seq_anode.
//   master : drives start, bin, signed_mode; observes busy, done and the results
//   slave  : the converter side
//   start/bin/signed_mode : conversion request and operand
//   busy/done             : conversion in progress / one-cycle result strobe
//   bcd/neg/overflow/disp : last result (BCD, sign, too-large flag, active-low segments)
interface bin_bcd_7seg_seq_anode_if #(
    parameter int WIDTH  = 12,
    parameter int DIGITS = 4
);
    logic                  start;
    logic [WIDTH-1:0]      bin;
    logic                  signed_mode;
    logic                  busy;
    logic                  done;
    logic [4*DIGITS-1:0]   bcd;
    logic                  neg;
    logic                  overflow;
    logic [8*DIGITS-1:0]   disp;

    modport master (
        output start, bin, signed_mode,
        input  busy, done, bcd, neg, overflow, disp
    );

    modport slave (
        input  start, bin, signed_mode,
        output busy, done, bcd, neg, overflow, disp
    );
endinterface

// File: rtl/bin_bcd_7seg_seq_anode.sv
// Sequential binary-to-BCD converter (double dabble, one bit per clock) driving a
// bank of common-anode 7-segment digits. Optional two's-complement input with a
// minus sign in the top digit; values too large for the display show all minus.
//   clk  : rising-edge clock
//   rst  : asynchronous active-high reset
//   bus  : slave modport of bin_bcd_7seg_seq_anode_if (start/bin/signed_mode in,
//          busy/done/bcd/neg/overflow/disp out)
// Build option: define BIN_BCD_LZB_EN to blank leading zero digits.
module bin_bcd_7seg_seq_anode #(
    parameter int WIDTH  = 12,
    parameter int DIGITS = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    bin_bcd_7seg_seq_anode_if.slave    bus
);
    // Scratch digits: ceil((WIDTH+3)/3) is enough for any WIDTH.
    localparam int S  = (WIDTH + 5) / 3;
    localparam int SX = (S > DIGITS) ? S : DIGITS;
    localparam int CW = $clog2(WIDTH + 1);

`ifdef BIN_BCD_LZB_EN
    localparam bit LZB = 1'b1;
`else
    localparam bit LZB = 1'b0;
`endif

    localparam logic [7:0] SEG_MINUS = 8'hBF;
    localparam logic [7:0] SEG_BLANK = 8'hFF;

    typedef enum logic [1:0] {st_idle, st_shift, st_load} state_t;

    state_t              state;
    logic [CW-1:0]       cnt;
    logic [WIDTH-1:0]    mag;
    logic [4*S-1:0]      scratch;
    logic                neg_int;

    logic [4*S-1:0]      adj;
    logic [4*SX-1:0]     ext;
    logic                ovf_next;
    logic [8*DIGITS-1:0] disp_next;

    function automatic logic [7:0] seg7(input logic [3:0] d);
        case (d)
            4'd0:    seg7 = 8'hC0;
            4'd1:    seg7 = 8'hF9;
            4'd2:    seg7 = 8'hA4;
            4'd3:    seg7 = 8'hB0;
            4'd4:    seg7 = 8'h99;
            4'd5:    seg7 = 8'h92;
            4'd6:    seg7 = 8'h82;
            4'd7:    seg7 = 8'hF8;
            4'd8:    seg7 = 8'h80;
            4'd9:    seg7 = 8'h90;
            default: seg7 = SEG_BLANK;
        endcase
    endfunction

    // Add-3 correction applied before each shift.
    always_comb begin
        adj = scratch;
        for (int i = 0; i < S; i++) begin
            if (scratch[4*i +: 4] >= 4'd5) begin
                adj[4*i +: 4] = scratch[4*i +: 4] + 4'd3;
            end
        end
    end

    // Result decode from the finished scratch; only registered in st_load.
    always_comb begin
        int  lim;
        logic blank_run;
        logic [3:0] d;

        ext       = (4*SX)'(scratch);
        lim       = neg_int ? DIGITS - 1 : DIGITS;
        ovf_next  = 1'b0;
        for (int i = 0; i < SX; i++) begin
            if (i >= lim && ext[4*i +: 4] != 4'd0) begin
                ovf_next = 1'b1;
            end
        end

        // Walk from the top digit down; blank_run stays set while only zeros seen.
        blank_run = LZB;
        disp_next = '1;
        for (int i = DIGITS - 1; i >= 0; i--) begin
            d = ext[4*i +: 4];
            if (ovf_next) begin
                disp_next[8*i +: 8] = SEG_MINUS;
            end else if (neg_int && i == DIGITS - 1) begin
                disp_next[8*i +: 8] = SEG_MINUS;
            end else begin
                if (d != 4'd0) begin
                    blank_run = 1'b0;
                end
                if (blank_run && i != 0) begin
                    disp_next[8*i +: 8] = SEG_BLANK;
                end else begin
                    disp_next[8*i +: 8] = seg7(d);
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= st_idle;
            cnt          <= '0;
            mag          <= '0;
            scratch      <= '0;
            neg_int      <= 1'b0;
            bus.busy     <= 1'b0;
            bus.done     <= 1'b0;
            bus.bcd      <= '0;
            bus.neg      <= 1'b0;
            bus.overflow <= 1'b0;
            bus.disp     <= '1;
        end else begin
            bus.done <= 1'b0;
            case (state)
                st_idle: begin
                    if (bus.start) begin
                        // Magnitude of the most negative value wraps to 2^(WIDTH-1),
                        // which is still right when read as unsigned.
                        if (bus.signed_mode && bus.bin[WIDTH-1]) begin
                            mag     <= -bus.bin;
                            neg_int <= 1'b1;
                        end else begin
                            mag     <= bus.bin;
                            neg_int <= 1'b0;
                        end
                        scratch  <= '0;
                        cnt      <= CW'(WIDTH);
                        bus.busy <= 1'b1;
                        state    <= st_shift;
                    end
                end
                st_shift: begin
                    scratch <= {adj[4*S-2:0], mag[WIDTH-1]};
                    mag     <= {mag[WIDTH-2:0], 1'b0};
                    cnt     <= cnt - 1'b1;
                    if (cnt == CW'(1)) begin
                        state <= st_load;
                    end
                end
                st_load: begin
                    bus.bcd      <= ext[4*DIGITS-1:0];
                    bus.neg      <= neg_int;
                    bus.overflow <= ovf_next;
                    bus.disp     <= disp_next;
                    bus.done     <= 1'b1;
                    bus.busy     <= 1'b0;
                    state        <= st_idle;
                end
                default: state <= st_idle;
            endcase
        end
    end
endmodule

// File: tb/tb_bin_bcd_7seg_seq_anode.sv
module tb_bin_bcd_7seg_seq_anode;
`ifdef BIN_BCD_LZB_EN
    localparam bit LZB = 1'b1;
`else
    localparam bit LZB = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   total = 0;
    int   bad   = 0;

    logic [15:0] prev_bcd  = 16'h0000;
    logic [31:0] prev_disp = 32'hFFFF_FFFF;

    always #5 clk = ~clk;

    bin_bcd_7seg_seq_anode_if #(.WIDTH(12), .DIGITS(4)) bus ();

    bin_bcd_7seg_seq_anode #(.WIDTH(12), .DIGITS(4)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct {
        logic [11:0] bin;
        logic        sm;
        logic [15:0] bcd;
        logic        neg;
        logic        ovf;
        logic [31:0] disp;
    } vec_t;

    vec_t vecs[12];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Issue one conversion and check latency, hold-during-busy and the result.
    task automatic run_conv(input vec_t v, input string tag);
        int cycles;
        @(negedge clk);
        bus.start       = 1'b1;
        bus.bin         = v.bin;
        bus.signed_mode = v.sm;
        @(posedge clk);
        #1;
        check({tag, " busy at accept"}, 64'(bus.busy), 64'd1);
        @(negedge clk);
        bus.start = 1'b0;
        cycles = 0;
        while (bus.done !== 1'b1 && cycles < 40) begin
            @(posedge clk);
            #1;
            cycles++;
            if (cycles == 5) begin
                check({tag, " held bcd"}, 64'(bus.bcd), 64'(prev_bcd));
                check({tag, " held disp"}, 64'(bus.disp), 64'(prev_disp));
            end
        end
        check({tag, " latency"}, 64'(cycles), 64'd13);
        check({tag, " bcd"}, 64'(bus.bcd), 64'(v.bcd));
        check({tag, " neg"}, 64'(bus.neg), 64'(v.neg));
        check({tag, " ovf"}, 64'(bus.overflow), 64'(v.ovf));
        check({tag, " disp"}, 64'(bus.disp), 64'(v.disp));
        check({tag, " busy low at done"}, 64'(bus.busy), 64'd0);
        @(posedge clk);
        #1;
        check({tag, " done one cycle"}, 64'(bus.done), 64'd0);
        prev_bcd  = v.bcd;
        prev_disp = v.disp;
    endtask

    initial begin
        int   cycles;
        int   dones;
        vec_t v;

        vecs[0]  = '{12'd4095, 1'b0, 16'h4095, 1'b0, 1'b0, 32'h99C0_9092};
        vecs[1]  = '{12'hFFF,  1'b1, 16'h0001, 1'b1, 1'b0,
                     LZB ? 32'hBFFF_FFF9 : 32'hBFC0_C0F9};
        vecs[2]  = '{12'h800,  1'b1, 16'h2048, 1'b1, 1'b1, 32'hBFBF_BFBF};
        vecs[3]  = '{12'h7FF,  1'b1, 16'h2047, 1'b0, 1'b0, 32'hA4C0_99F8};
        vecs[4]  = '{12'd0,    1'b0, 16'h0000, 1'b0, 1'b0,
                     LZB ? 32'hFFFF_FFC0 : 32'hC0C0_C0C0};
        vecs[5]  = '{12'hC19,  1'b1, 16'h0999, 1'b1, 1'b0, 32'hBF90_9090};
        vecs[6]  = '{12'hC18,  1'b1, 16'h1000, 1'b1, 1'b1, 32'hBFBF_BFBF};
        vecs[7]  = '{12'h800,  1'b0, 16'h2048, 1'b0, 1'b0, 32'hA4C0_9980};
        vecs[8]  = '{12'd10,   1'b0, 16'h0010, 1'b0, 1'b0,
                     LZB ? 32'hFFFF_F9C0 : 32'hC0C0_F9C0};
        vecs[9]  = '{12'd5,    1'b1, 16'h0005, 1'b0, 1'b0,
                     LZB ? 32'hFFFF_FF92 : 32'hC0C0_C092};
        vecs[10] = '{12'd1234, 1'b0, 16'h1234, 1'b0, 1'b0, 32'hF9A4_B099};
        vecs[11] = '{12'd678,  1'b0, 16'h0678, 1'b0, 1'b0,
                     LZB ? 32'hFF82_F880 : 32'hC082_F880};

        bus.start       = 1'b0;
        bus.bin         = '0;
        bus.signed_mode = 1'b0;
        #12;
        check("reset busy", 64'(bus.busy), 64'd0);
        check("reset done", 64'(bus.done), 64'd0);
        check("reset bcd", 64'(bus.bcd), 64'd0);
        check("reset neg", 64'(bus.neg), 64'd0);
        check("reset ovf", 64'(bus.overflow), 64'd0);
        check("reset disp", 64'(bus.disp), 64'hFFFF_FFFF);
        @(negedge clk);
        rst = 1'b0;

        for (int i = 0; i < 12; i++) begin
            run_conv(vecs[i], $sformatf("vec%0d", i));
        end

        // start re-pulsed while busy must be ignored
        @(negedge clk);
        bus.start = 1'b1;
        bus.bin   = 12'd100;
        bus.signed_mode = 1'b0;
        @(posedge clk);
        #1;
        @(negedge clk);
        bus.start = 1'b0;
        repeat (2) @(negedge clk);
        bus.start = 1'b1;
        bus.bin   = 12'd5;
        @(negedge clk);
        bus.start = 1'b0;
        dones = 0;
        for (int c = 0; c < 30; c++) begin
            @(posedge clk);
            #1;
            if (bus.done === 1'b1) begin
                dones++;
                check("busy-ignore bcd", 64'(bus.bcd), 64'h0100);
                check("busy-ignore disp", 64'(bus.disp),
                      LZB ? 64'hFFF9_C0C0 : 64'hC0F9_C0C0);
            end
        end
        check("busy-ignore done count", 64'(dones), 64'd1);

        // Asynchronous reset in the middle of a conversion
        @(negedge clk);
        bus.start = 1'b1;
        bus.bin   = 12'd1234;
        @(posedge clk);
        @(negedge clk);
        bus.start = 1'b0;
        repeat (6) @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        check("midrst busy", 64'(bus.busy), 64'd0);
        check("midrst bcd", 64'(bus.bcd), 64'd0);
        check("midrst disp", 64'(bus.disp), 64'hFFFF_FFFF);
        check("midrst ovf", 64'(bus.overflow), 64'd0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        dones = 0;
        for (int c = 0; c < 20; c++) begin
            @(posedge clk);
            #1;
            if (bus.done === 1'b1) dones++;
        end
        check("midrst no done", 64'(dones), 64'd0);
        prev_bcd  = 16'h0000;
        prev_disp = 32'hFFFF_FFFF;
        v = '{12'd7, 1'b0, 16'h0007, 1'b0, 1'b0,
              LZB ? 32'hFFFF_FFF8 : 32'hC0C0_C0F8};
        run_conv(v, "post-rst");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "timeout");
    end
endmodule

// File: doc/bin_bcd_7seg_seq_anode.md
Name: bin_bcd_7seg_seq_anode

Overview:
- Sequential, parametrised binary-to-decimal display driver for common-anode 7-segment banks.
- Converts one bit per clock using double dabble (shift-and-add-3), with a start/busy/done handshake.
- Supports optional two's-complement input with a minus sign, and flags values too large to display.
- Sits between datapath registers and the board 7-segment pins; it replaces the combinational 12-bit/4-digit decoder with one that is area-cheap at any width.

Parameters:
- WIDTH, 12, binary input width in bits (2 or more).
- DIGITS, 4, number of 7-segment digits driven (2 or more).

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  reset, asynchronous, active-high.
- start  in  1  request a conversion; sampled only while idle.
- bin  in  WIDTH  operand, captured on an accepted start.
- signed_mode  in  1  1 = bin is two's complement; captured with bin.
- busy  out  1  high from the edge that accepts start until the result edge.
- done  out  1  one-cycle pulse on the cycle results update.
- bcd  out  4*DIGITS  BCD of the magnitude; digit 0 is in the LSBs.
- neg  out  1  the last result was negative.
- overflow  out  1  the last result did not fit in the display.
- disp  out  8*DIGITS  segment bytes {DP,G,F,E,D,C,B,A}, active-low; disp[7:0] is the units digit.

Behaviour:
- Reset (async, any time, including mid-conversion):
  - State goes to IDLE; busy=0, done=0, neg=0, overflow=0, bcd=0.
  - Every disp byte = 8'hFF (blank).
  - Any in-flight conversion is discarded.
- States are IDLE, SHIFT and LOAD.
- IDLE:
  - On start=1 at a clock edge, capture the operand.
  - If signed_mode=1 and bin[WIDTH-1]=1, set the internal neg flag and take the magnitude as 0-bin modulo 2^WIDTH. The most negative value therefore gives 2^(WIDTH-1), which is correct as unsigned.
  - Otherwise neg=0 and the magnitude is bin.
  - Clear the scratch BCD, set busy=1, load bit counter = WIDTH, and go to SHIFT.
- SHIFT, once per clock:
  - Add 3 to every scratch digit that is 5 or more.
  - Then shift {scratch, magnitude} left by one.
  - Decrement the counter; after the WIDTH-th shift, go to LOAD.
  - Scratch width is 4*S, with S = ceil((WIDTH+3)/3) digits, enough for any WIDTH.
- LOAD, one cycle:
  - Register bcd, neg, overflow and disp.
  - Assert done=1 for this cycle, set busy=0 and return to IDLE.
- Latency: start sampled at edge k gives busy=1 from k, and done=1 with new outputs from edge k+WIDTH+1 for one cycle. The next start is accepted at edge k+WIDTH+2 or later.
- start while busy=1 is ignored; there is no queueing.
- Outputs (bcd, neg, overflow, disp) hold their previous values throughout a conversion.
- Displayable digits: DIGITS when neg=0, DIGITS-1 when neg=1 (the top digit is reserved for the sign).
- overflow=1 if any scratch digit at or above the displayable count is nonzero.
- bcd always holds the low DIGITS scratch digits.
- Digit encodings, active-low:
  - 0:C0, 1:F9, 2:A4, 3:B0, 4:99, 5:92, 6:82, 7:F8, 8:80, 9:90.
  - minus = 8'hBF; blank = 8'hFF.
  - DP bit is always 1 (off).
- Display mapping:
  - overflow=1: every digit shows minus (8'hBF).
  - neg=1: the top digit shows minus; the lower DIGITS-1 digits show BCD.
  - neg=0: all DIGITS digits show BCD.

Optional Feature:
- Macro BIN_BCD_LZB_EN enables leading-zero blanking.
- When defined:
  - Zero digits above the most significant nonzero digit show blank (8'hFF). The units digit is never blanked.
  - The minus sign still occupies the top digit.
  - Overflow display is unaffected.
- When undefined: leading zeros display as 0 (8'hC0).

Test Plan:
- Defaults, unsigned, bin=12'd4095, start pulse:
  - busy rises at the start edge; done pulses exactly 13 cycles later.
  - bcd=16'h4095, disp={99,C0,90,92} (digit 3 down to 0), overflow=0.
- signed_mode=1, bin=12'hFFF (-1), LZB off:
  - neg=1, bcd=16'h0001, disp={BF,C0,C0,F9}.
- signed_mode=1, bin=12'h800 (-2048):
  - overflow=1, disp={BF,BF,BF,BF}.
- signed_mode=1, bin=12'h7FF (2047):
  - overflow=0, bcd=16'h2047.
- start re-pulsed with bin=5 during busy:
  - Ignored; the result reflects the first operand; done pulses once.
- rst asserted at cycle 6 of a conversion:
  - Outputs are blank/zero immediately; no done follows.
  - A new start (bin=7) gives disp0=F8 and bcd=16'h0007.
  - With BIN_BCD_LZB_EN defined, disp3..1=FF.
